clock_group_reset_sequencer: RTL

CLOCK_GROUP_RESET_SEQUENCER -- requirements
Module: clock_group_reset_sequencer

---
 rtl/clock_group_reset_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/clock_group_reset_sequencer.sv
// Clock-group reset sequencer: synchronizes reset release, holds both
// member resets, then releases l2_0 and l2_1 in a staggered order.
module clock_group_reset_sequencer #(
  parameter int SYNC_STAGES    = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_sw_reset_req_valid,
  output logic       io_sw_reset_req_ready,
  output logic       auto_out_member_subsystem_l2_0_clock,
  output logic       auto_out_member_subsystem_l2_0_reset,
  output logic       auto_out_member_subsystem_l2_1_clock,
  output logic       auto_out_member_subsystem_l2_1_reset,
  output logic [1:0] io_state,
  output logic       io_done
);

  localparam int MAX_HS =
    (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int MAX_C = (MAX_HS > 2) ? MAX_HS : 2;
  localparam int CW = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST =
    CW'((STAGGER_CYCLES == 0) ? 0 : STAGGER_CYCLES - 1);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HOLD = 2'd1,
    REL0 = 2'd2,
    RUN  = 2'd3
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   accept;
  logic                   r0_q;
  logic                   r1_q;
  logic                   done_q;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign accept   = io_sw_reset_req_valid && (state_q == RUN);

  assign auto_out_member_subsystem_l2_0_clock = clock;
  assign auto_out_member_subsystem_l2_1_clock = clock;
  assign auto_out_member_subsystem_l2_0_reset = r0_q;
  assign auto_out_member_subsystem_l2_1_reset = r1_q;
  assign io_sw_reset_req_ready = (state_q == RUN);
  assign io_state = state_q;
  assign io_done  = done_q;

  // Release synchronizer: flushed by reset, fills with ones afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  // State, counter and registered reset/done outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      r0_q    <= 1'b1;
      r1_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r0_q    <= (state_d == SYNC) || (state_d == HOLD);
      r1_q    <= (state_d != RUN);
      done_q  <= (state_d == RUN) && (state_q != RUN);
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SYNC: begin
        if (sync_out) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = (STAGGER_CYCLES == 0) ? RUN : REL0;
        end
      end
      REL0: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == STAG_LAST) begin
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SYNC;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
